// File: rtl/rv_iopmp_pkg.sv
// ============================================================================
// Module      : rv_iopmp_pkg
// Description : Shared IOPMP types (access type encoding).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_iopmp_pkg;

    typedef enum logic [1:0] {
        ACCESS_NONE  = 2'd0,
        ACCESS_READ  = 2'd1,
        ACCESS_WRITE = 2'd2,
        ACCESS_EXEC  = 2'd3
    } access_t;

endpackage

`default_nettype wire

// File: rtl/rv_iopmp_check_requester.sv
// ============================================================================
// Module      : rv_iopmp_check_requester
// Description : Sequences one IOPMP permission check per request: validates
//               the request, issues it to the checker, waits (with timeout)
//               for the verdict and holds the response until consumed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_iopmp_check_requester
    import rv_iopmp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned SID_WIDTH      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    // Value at which the deny counter stops counting.
    parameter logic [15:0] DENY_SAT       = 16'hFFFF
) (
    input  logic                            clk_i,
    input  logic                            rst_i,

    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [ADDR_WIDTH-1:0]           req_addr_i,
    input  logic [$clog2(DATA_WIDTH/8):0]   req_num_bytes_i,
    input  logic [SID_WIDTH-1:0]            req_sid_i,
    input  access_t                         req_access_i,

    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic                            rsp_allow_o,
    output logic                            rsp_timeout_o,

    output logic                            chk_transaction_en_o,
    output logic [ADDR_WIDTH-1:0]           chk_addr_o,
    output logic [$clog2(DATA_WIDTH/8):0]   chk_num_bytes_o,
    output logic [SID_WIDTH-1:0]            chk_sid_o,
    output access_t                         chk_access_type_o,
    input  logic                            chk_ready_i,
    input  logic                            chk_valid_i,
    input  logic                            chk_allow_i,

    output logic                            busy_o,
    output logic [15:0]                     deny_count_o
);

    localparam int NBW = $clog2(DATA_WIDTH/8) + 1;
    localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [NBW-1:0] c_NB_MAX  = NBW'(DATA_WIDTH/8);
    localparam logic [CW-1:0]  c_TIMEOUT = CW'(TIMEOUT_CYCLES);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [NBW-1:0]        r_num_bytes;
    logic [SID_WIDTH-1:0]  r_sid;
    access_t               r_access;
    logic                  r_allow;
    logic                  r_timeout;
    logic [CW-1:0]         r_wait_cnt;
    logic [15:0]           r_deny_count;

    logic                  w_reject;
    logic [CW-1:0]         w_wait_cnt_next;
    logic                  w_valid_ok;
    logic                  w_expired;

    assign w_reject = (req_num_bytes_i == '0) || (req_num_bytes_i > c_NB_MAX) ||
                      (req_access_i == ACCESS_NONE);

    // The first WAIT cycle (counter still 0) may carry a stale checker valid.
    assign w_wait_cnt_next = r_wait_cnt + CW'(1);
    assign w_valid_ok      = chk_valid_i && (r_wait_cnt != '0);
    assign w_expired       = (w_wait_cnt_next == c_TIMEOUT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= c_IDLE;
            r_addr       <= '0;
            r_num_bytes  <= '0;
            r_sid        <= '0;
            r_access     <= ACCESS_NONE;
            r_allow      <= 1'b0;
            r_timeout    <= 1'b0;
            r_wait_cnt   <= '0;
            r_deny_count <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid_i) begin
                        r_addr      <= req_addr_i;
                        r_num_bytes <= req_num_bytes_i;
                        r_sid       <= req_sid_i;
                        r_access    <= req_access_i;
                        r_allow     <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_state     <= w_reject ? c_RESP : c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    if (chk_ready_i) begin
                        r_wait_cnt <= '0;
                        r_state    <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    r_wait_cnt <= w_wait_cnt_next;
                    // A valid verdict takes priority over an expiring timeout.
                    if (w_valid_ok) begin
                        r_allow   <= chk_allow_i;
                        r_timeout <= 1'b0;
                        r_state   <= c_RESP;
                    end else if (w_expired) begin
                        r_allow   <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= c_RESP;
                    end
                end
                c_RESP: begin
                    if (rsp_ready_i) begin
                        if (!r_allow && (r_deny_count != DENY_SAT)) begin
                            r_deny_count <= r_deny_count + 16'd1;
                        end
                        r_addr      <= '0;
                        r_num_bytes <= '0;
                        r_sid       <= '0;
                        r_access    <= ACCESS_NONE;
                        r_allow     <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign req_ready_o          = (r_state == c_IDLE);
    assign busy_o               = (r_state != c_IDLE);
    assign rsp_valid_o          = (r_state == c_RESP);
    assign rsp_allow_o          = r_allow;
    assign rsp_timeout_o        = r_timeout;
    assign chk_transaction_en_o = (r_state == c_ISSUE) && chk_ready_i;
    assign chk_addr_o           = r_addr;
    assign chk_num_bytes_o      = r_num_bytes;
    assign chk_sid_o            = r_sid;
    assign chk_access_type_o    = r_access;
    assign deny_count_o         = r_deny_count;

endmodule

`default_nettype wire

// File: tb/tb_rv_iopmp_check_requester.sv
// ============================================================================
// Module      : tb_rv_iopmp_check_requester
// Description : Directed self-checking bench for rv_iopmp_check_requester.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_iopmp_check_requester;
    import rv_iopmp_pkg::*;

    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int SW  = 8;
    localparam int TO  = 4;
    localparam int NBW = $clog2(DW/8) + 1;
    localparam logic [15:0] SAT = 16'd8;

    logic           clk;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [AW-1:0]  req_addr;
    logic [NBW-1:0] req_num_bytes;
    logic [SW-1:0]  req_sid;
    access_t        req_access;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_allow;
    logic           rsp_timeout;
    logic           chk_en;
    logic [AW-1:0]  chk_addr;
    logic [NBW-1:0] chk_num_bytes;
    logic [SW-1:0]  chk_sid;
    access_t        chk_access;
    logic           chk_ready;
    logic           chk_valid;
    logic           chk_allow;
    logic           busy;
    logic [15:0]    deny_count;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    rv_iopmp_check_requester #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .SID_WIDTH     (SW),
        .TIMEOUT_CYCLES(TO),
        .DENY_SAT      (SAT)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .req_valid_i         (req_valid),
        .req_ready_o         (req_ready),
        .req_addr_i          (req_addr),
        .req_num_bytes_i     (req_num_bytes),
        .req_sid_i           (req_sid),
        .req_access_i        (req_access),
        .rsp_valid_o         (rsp_valid),
        .rsp_ready_i         (rsp_ready),
        .rsp_allow_o         (rsp_allow),
        .rsp_timeout_o       (rsp_timeout),
        .chk_transaction_en_o(chk_en),
        .chk_addr_o          (chk_addr),
        .chk_num_bytes_o     (chk_num_bytes),
        .chk_sid_o           (chk_sid),
        .chk_access_type_o   (chk_access),
        .chk_ready_i         (chk_ready),
        .chk_valid_i         (chk_valid),
        .chk_allow_i         (chk_allow),
        .busy_o              (busy),
        .deny_count_o        (deny_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chk_en === 1'b1) pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [AW-1:0] a, input logic [NBW-1:0] nb,
                             input logic [SW-1:0] s, input access_t acc);
        req_valid     = 1'b1;
        req_addr      = a;
        req_num_bytes = nb;
        req_sid       = s;
        req_access    = acc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (chk_en !== 1'b0) begin n_fail++; $display("FAIL reset_chk_en: got %b want 0", chk_en); end
        n_checks++; if (chk_access !== ACCESS_NONE) begin n_fail++; $display("FAIL reset_chk_access: got %0d want 0", chk_access); end
        n_checks++; if (chk_addr !== '0) begin n_fail++; $display("FAIL reset_chk_addr: got %h want 0", chk_addr); end
        n_checks++; if (deny_count !== 16'd0) begin n_fail++; $display("FAIL reset_deny: got %0d want 0", deny_count); end
        n_checks++; if ({rsp_allow, rsp_timeout} !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_flags: got %b want 00", {rsp_allow, rsp_timeout}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_allow();
        int p0;
        p0 = pulses;
        chk_ready = 1'b1;
        drive_req(64'h8000_0000, 4'd8, 8'd3, ACCESS_READ);
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL allow_req_ready: got %b want 1", req_ready); end
        tick();                                  // ISSUE
        req_valid = 1'b0;
        #1;
        n_checks++; if (chk_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL allow_chk_addr: got %h want 80000000", chk_addr); end
        n_checks++; if (chk_num_bytes !== 4'd8) begin n_fail++; $display("FAIL allow_chk_nb: got %0d want 8", chk_num_bytes); end
        n_checks++; if (chk_sid !== 8'd3) begin n_fail++; $display("FAIL allow_chk_sid: got %0d want 3", chk_sid); end
        n_checks++; if (chk_access !== ACCESS_READ) begin n_fail++; $display("FAIL allow_chk_access: got %0d want 1", chk_access); end
        n_checks++; if (chk_en !== 1'b1) begin n_fail++; $display("FAIL allow_chk_en: got %b want 1", chk_en); end
        n_checks++; if (req_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL allow_busy: got ready=%b busy=%b want 0/1", req_ready, busy); end
        tick();                                  // WAIT 1
        n_checks++; if (chk_en !== 1'b0) begin n_fail++; $display("FAIL allow_chk_en_wait: got %b want 0", chk_en); end
        tick();                                  // WAIT 2
        chk_valid = 1'b1;
        chk_allow = 1'b1;
        #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL allow_early_rsp: got %b want 0", rsp_valid); end
        tick();                                  // RESP
        chk_valid = 1'b0;
        chk_allow = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL allow_rsp_valid: got %b want 1", rsp_valid); end
        n_checks++; if (rsp_allow !== 1'b1 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL allow_rsp_flags: got allow=%b to=%b want 1/0", rsp_allow, rsp_timeout); end
        n_checks++; if (pulses - p0 !== 1) begin n_fail++; $display("FAIL allow_pulses: got %0d want 1", pulses - p0); end
        n_checks++; if (chk_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL allow_chk_hold: got %h want 80000000", chk_addr); end
        rsp_ready = 1'b1;
        tick();                                  // IDLE
        rsp_ready = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || rsp_allow !== 1'b0) begin n_fail++; $display("FAIL allow_rsp_clear: got valid=%b allow=%b want 0/0", rsp_valid, rsp_allow); end
        n_checks++; if (chk_addr !== '0 || chk_access !== ACCESS_NONE) begin n_fail++; $display("FAIL allow_chk_clear: got addr=%h acc=%0d want 0/0", chk_addr, chk_access); end
        n_checks++; if (deny_count !== 16'd0) begin n_fail++; $display("FAIL allow_deny: got %0d want 0", deny_count); end
    endtask

    task automatic test_stale_valid();
        drive_req(64'h0000_1230, 4'd4, 8'd5, ACCESS_WRITE);
        tick();                                  // ISSUE
        req_valid = 1'b0;
        tick();                                  // WAIT 1: stale valid
        chk_valid = 1'b1;
        chk_allow = 1'b1;
        tick();                                  // WAIT 2
        chk_valid = 1'b0;
        chk_allow = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stale_accepted: got rsp_valid=%b want 0", rsp_valid); end
        tick();                                  // WAIT 3
        chk_valid = 1'b1;
        chk_allow = 1'b0;
        tick();                                  // RESP
        chk_valid = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_allow !== 1'b0 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL stale_rsp: got v=%b a=%b t=%b want 1/0/0", rsp_valid, rsp_allow, rsp_timeout); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++; if (deny_count !== 16'd1) begin n_fail++; $display("FAIL stale_deny: got %0d want 1", deny_count); end
    endtask

    task automatic test_reject();
        logic [NBW-1:0] nbs [3] = '{4'd0, 4'd9, 4'd4};
        access_t        accs[3] = '{ACCESS_READ, ACCESS_WRITE, ACCESS_NONE};
        for (int i = 0; i < 3; i++) begin
            int p0;
            p0 = pulses;
            drive_req(64'h0000_2000, nbs[i], 8'd1, accs[i]);
            tick();                              // RESP after one cycle
            req_valid = 1'b0;
            #1;
            n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL reject%0d_latency: got rsp_valid=%b want 1", i, rsp_valid); end
            n_checks++; if (rsp_allow !== 1'b0 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL reject%0d_flags: got a=%b t=%b want 0/0", i, rsp_allow, rsp_timeout); end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            n_checks++; if (pulses !== p0) begin n_fail++; $display("FAIL reject%0d_pulse: got %0d want %0d", i, pulses, p0); end
            n_checks++; if (deny_count !== 16'(2 + i)) begin n_fail++; $display("FAIL reject%0d_deny: got %0d want %0d", i, deny_count, 2 + i); end
        end
    endtask

    task automatic test_timeout();
        for (int wv = 0; wv < 2; wv++) begin
            drive_req(64'h0000_1000, 4'd4, 8'd7, ACCESS_WRITE);
            tick();                              // ISSUE
            req_valid = 1'b0;
            tick();                              // WAIT 1
            for (int w = 1; w <= TO; w++) begin
                if (w == TO && wv == 1) begin
                    chk_valid = 1'b1;
                    chk_allow = 1'b1;
                end
                #1;
                n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL timeout%0d_early_w%0d: got rsp_valid=%b want 0", wv, w, rsp_valid); end
                tick();
            end
            chk_valid = 1'b0;
            chk_allow = 1'b0;
            #1;
            n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL timeout%0d_rsp_valid: got %b want 1", wv, rsp_valid); end
            n_checks++; if (rsp_timeout !== (wv == 0) || rsp_allow !== (wv == 1)) begin n_fail++; $display("FAIL timeout%0d_flags: got t=%b a=%b want t=%0d a=%0d", wv, rsp_timeout, rsp_allow, wv == 0, wv == 1); end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            n_checks++; if (deny_count !== 16'd5) begin n_fail++; $display("FAIL timeout%0d_deny: got %0d want 5", wv, deny_count); end
        end
    endtask

    task automatic test_backpressure();
        int p0;
        p0 = pulses;
        chk_ready = 1'b0;
        drive_req(64'h0000_2000, 4'd2, 8'd1, ACCESS_EXEC);
        tick();                                  // ISSUE, checker busy
        req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if (chk_en !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_issue%0d: got en=%b busy=%b v=%b want 0/1/0", c, chk_en, busy, rsp_valid); end
            tick();
        end
        chk_ready = 1'b1;
        #1;
        n_checks++; if (chk_en !== 1'b1 || pulses !== p0) begin n_fail++; $display("FAIL bp_release: got en=%b pulses=%0d want 1/%0d", chk_en, pulses - p0, 0); end
        tick();                                  // WAIT 1
        tick();                                  // WAIT 2
        chk_valid = 1'b1;
        chk_allow = 1'b0;
        tick();                                  // RESP
        chk_valid = 1'b0;
        chk_allow = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (rsp_valid !== 1'b1 || rsp_allow !== 1'b0 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL bp_hold%0d: got v=%b a=%b t=%b want 1/0/0", c, rsp_valid, rsp_allow, rsp_timeout); end
            tick();
        end
        rsp_ready = 1'b1;
        drive_req(64'h0000_5000, 4'd8, 8'd2, ACCESS_READ);
        tick();                                  // handshake; request must not be taken
        rsp_ready = 1'b0;
        n_checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_same_cycle_accept: got ready=%b busy=%b v=%b want 1/0/0", req_ready, busy, rsp_valid); end
        req_valid = 1'b0;
        chk_allow = 1'b0;
        n_checks++; if (deny_count !== 16'd6 || pulses - p0 !== 1) begin n_fail++; $display("FAIL bp_counts: got deny=%0d pulses=%0d want 6/1", deny_count, pulses - p0); end
    endtask

    task automatic test_reset_in_wait();
        int p0;
        chk_ready = 1'b1;
        drive_req(64'h0000_3000, 4'd8, 8'd2, ACCESS_READ);
        tick();                                  // ISSUE
        req_valid = 1'b0;
        tick();                                  // WAIT 1
        tick();                                  // WAIT 2
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || chk_en !== 1'b0) begin n_fail++; $display("FAIL rstwait_state: got busy=%b ready=%b v=%b en=%b want 0/1/0/0", busy, req_ready, rsp_valid, chk_en); end
        n_checks++; if (deny_count !== 16'd0 || chk_addr !== '0 || chk_access !== ACCESS_NONE) begin n_fail++; $display("FAIL rstwait_regs: got deny=%0d addr=%h acc=%0d want 0/0/0", deny_count, chk_addr, chk_access); end
        rst = 1'b0;
        tick();
        p0 = pulses;
        drive_req(64'h0000_4000, 4'd1, 8'd9, ACCESS_WRITE);
        tick();                                  // ISSUE
        req_valid = 1'b0;
        tick();                                  // WAIT 1
        tick();                                  // WAIT 2
        chk_valid = 1'b1;
        chk_allow = 1'b1;
        tick();                                  // RESP
        chk_valid = 1'b0;
        chk_allow = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_allow !== 1'b1 || pulses - p0 !== 1) begin n_fail++; $display("FAIL rstwait_next: got v=%b a=%b pulses=%0d want 1/1/1", rsp_valid, rsp_allow, pulses - p0); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++; if (deny_count !== 16'd0) begin n_fail++; $display("FAIL rstwait_deny: got %0d want 0", deny_count); end
    endtask

    task automatic test_deny_saturation();
        for (int i = 1; i <= 10; i++) begin
            logic [15:0] exp_cnt;
            exp_cnt = (i < int'(SAT)) ? 16'(i) : SAT;
            drive_req(64'h0, 4'd0, 8'd0, ACCESS_READ);
            tick();                              // RESP
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            #1;
            n_checks++; if (deny_count !== exp_cnt) begin n_fail++; $display("FAIL sat%0d_deny: got %0d want %0d", i, deny_count, exp_cnt); end
        end
    endtask

    initial begin
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_addr      = '0;
        req_num_bytes = '0;
        req_sid       = '0;
        req_access    = ACCESS_NONE;
        rsp_ready     = 1'b0;
        chk_ready     = 1'b1;
        chk_valid     = 1'b0;
        chk_allow     = 1'b0;

        test_reset();
        test_allow();
        test_stale_valid();
        test_reject();
        test_timeout();
        test_backpressure();
        test_reset_in_wait();
        test_deny_saturation();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
